// File: rtl/lane_mem_sequencer.sv
// Serialises per-lane LW/SW accesses from the SIMT execute stage onto the
// single-port data memory, gathering load results back per lane.
module lane_mem_sequencer #(
    parameter int LANES  = 16,
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     is_store,
    input  logic [LANES-1:0]         lane_mask,
    input  logic [LANES*ADDR_W-1:0]  addr_flat,
    input  logic [LANES*DATA_W-1:0]  wdata_flat,
    output logic                     busy,
    output logic                     done,
    output logic [LANES*DATA_W-1:0]  rdata_flat,
    output logic                     mem_en,
    output logic                     mem_we,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [DATA_W-1:0]        mem_wdata,
    input  logic [DATA_W-1:0]        mem_rdata
);

    localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } state_t;

    state_t                   state;
    state_t                   state_nx;
    logic                     st_store;
    logic [LANES-1:0]         rem;
    logic [LANES-1:0]         rem_nx;
    logic [LANES*ADDR_W-1:0]  addr_q;
    logic [LANES*DATA_W-1:0]  wdata_q;
    logic [LW-1:0]            sel;
    logic [LW-1:0]            tag;
    logic                     cap_vld;

    // Lowest remaining lane goes first.
    always_comb begin
        sel = '0;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (rem[i]) sel = LW'(i);
        end
    end

    assign rem_nx = rem & (rem - LANES'(1));

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (start) state_nx = (lane_mask != '0) ? ISSUE : DONE;
            end
            ISSUE: begin
                if (rem_nx == '0) state_nx = st_store ? DONE : DRAIN;
            end
            DRAIN:   state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Outputs decode straight from state so reset kills the strobe at once.
    always_comb begin
        mem_en    = (state == ISSUE);
        mem_we    = mem_en & st_store;
        mem_addr  = '0;
        mem_wdata = '0;
        if (mem_en) begin
            mem_addr  = addr_q[sel*ADDR_W +: ADDR_W];
            mem_wdata = wdata_q[sel*DATA_W +: DATA_W];
        end
        busy = (state == ISSUE) || (state == DRAIN);
        done = (state == DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            st_store   <= 1'b0;
            rem        <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            tag        <= '0;
            cap_vld    <= 1'b0;
            rdata_flat <= '0;
        end else begin
            state   <= state_nx;
            cap_vld <= (state == ISSUE) && !st_store;
            if (state == ISSUE) begin
                rem <= rem_nx;
                tag <= sel;
            end
            // Read data lands one cycle after its strobe.
            if (cap_vld) rdata_flat[tag*DATA_W +: DATA_W] <= mem_rdata;
            if (state == IDLE && start) begin
                st_store   <= is_store;
                rem        <= lane_mask;
                addr_q     <= addr_flat;
                wdata_q    <= wdata_flat;
                rdata_flat <= '0;
            end
        end
    end

endmodule

// File: tb/tb_lane_mem_sequencer.sv
// Directed bench for lane_mem_sequencer with a one-cycle-latency
// synchronous memory model.
module tb_lane_mem_sequencer;

    logic         clk;
    logic         reset;
    logic         start;
    logic         is_store;
    logic [15:0]  lane_mask;
    logic [255:0] addr_flat;
    logic [255:0] wdata_flat;
    logic         busy;
    logic         done;
    logic [255:0] rdata_flat;
    logic         mem_en;
    logic         mem_we;
    logic [15:0]  mem_addr;
    logic [15:0]  mem_wdata;
    logic [15:0]  mem_rdata;

    lane_mem_sequencer #(
        .LANES (16),
        .ADDR_W(16),
        .DATA_W(16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .is_store  (is_store),
        .lane_mask (lane_mask),
        .addr_flat (addr_flat),
        .wdata_flat(wdata_flat),
        .busy      (busy),
        .done      (done),
        .rdata_flat(rdata_flat),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    logic [15:0] mem [0:255];

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
            else        mem_rdata <= mem[mem_addr[7:0]];
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests  = 0;
    int failed = 0;

    int en_n;
    int busy_n;
    int done_n;
    int done_cyc;
    int first_en;
    int last_en;
    int busy_bad;
    logic [15:0] seen [$];
    logic [255:0] exp_v;

    task automatic chk(input string tag, input logic [255:0] obs,
                       input logic [255:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic fill(input logic [15:0] abase, input logic [15:0] dbase);
        for (int i = 0; i < 16; i++) begin
            addr_flat[i*16 +: 16]  = abase + 16'(i);
            wdata_flat[i*16 +: 16] = dbase + 16'(i);
        end
    endtask

    // Presents a start pulse; returns #1 into cycle 1.
    task automatic launch(input logic st, input logic [15:0] mask);
        is_store  = st;
        lane_mask = mask;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start     = 1'b0;
    endtask

    // Samples cycles 1..limit; optionally re-pulses start at pulse_at.
    task automatic observe(input int limit, input int pulse_at);
        en_n = 0; busy_n = 0; done_n = 0; done_cyc = 0;
        first_en = 0; last_en = 0; busy_bad = 0;
        seen.delete();
        for (int c = 1; c <= limit; c++) begin
            if (done_cyc != 0 && c > done_cyc + 2) break;
            if (c == pulse_at) begin
                start     = 1'b1;
                lane_mask = 16'hFFFF;
                is_store  = ~is_store;
                addr_flat = '0;
            end else begin
                start = 1'b0;
            end
            if (mem_en) begin
                en_n++;
                if (first_en == 0) first_en = c;
                last_en = c;
                seen.push_back(mem_addr);
            end
            if (busy) busy_n++;
            if (done) begin
                done_n++;
                if (done_cyc == 0) done_cyc = c;
                if (busy) busy_bad = 1;
            end
            if (done_cyc != 0 && c > done_cyc && busy) busy_bad = 1;
            @(posedge clk);
            #1;
        end
        start = 1'b0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; is_store = 1'b0;
        lane_mask = '0; addr_flat = '0; wdata_flat = '0;
        #1;
        chk("rst_busy",  256'(busy), 256'(0));
        chk("rst_done",  256'(done), 256'(0));
        chk("rst_en",    256'(mem_en), 256'(0));
        chk("rst_we",    256'(mem_we), 256'(0));
        chk("rst_addr",  256'(mem_addr), 256'(0));
        chk("rst_wdata", 256'(mem_wdata), 256'(0));
        chk("rst_rdata", rdata_flat, 256'(0));
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        // 1: 16-lane store
        fill(16'h0010, 16'hA000);
        launch(1'b1, 16'hFFFF);
        observe(40, 0);
        chk("t1_en_n",   256'(en_n), 256'(16));
        chk("t1_first",  256'(first_en), 256'(1));
        chk("t1_last",   256'(last_en), 256'(16));
        chk("t1_done",   256'(done_cyc), 256'(17));
        chk("t1_done_n", 256'(done_n), 256'(1));
        chk("t1_busy_n", 256'(busy_n), 256'(16));
        chk("t1_busy_x", 256'(busy_bad), 256'(0));
        for (int i = 0; i < seen.size(); i++)
            chk($sformatf("t1_order%0d", i), 256'(seen[i]), 256'(16'h10 + i));
        chk("t1_mem1f", 256'(mem[8'h1F]), 256'(16'hA00F));
        chk("t1_mem10", 256'(mem[8'h10]), 256'(16'hA000));

        // 2: sparse load lanes 0 and 15
        fill(16'h0010, 16'h0000);
        launch(1'b0, 16'h8001);
        observe(40, 0);
        chk("t2_en_n",   256'(en_n), 256'(2));
        chk("t2_done",   256'(done_cyc), 256'(4));
        chk("t2_busy_n", 256'(busy_n), 256'(3));
        chk("t2_busy_x", 256'(busy_bad), 256'(0));
        exp_v = '0;
        exp_v[0 +: 16]   = 16'hA000;
        exp_v[240 +: 16] = 16'hA00F;
        chk("t2_rdata", rdata_flat, exp_v);

        // 3: empty mask
        launch(1'b0, 16'h0000);
        observe(20, 0);
        chk("t3_en_n",   256'(en_n), 256'(0));
        chk("t3_done",   256'(done_cyc), 256'(1));
        chk("t3_done_n", 256'(done_n), 256'(1));
        chk("t3_busy_n", 256'(busy_n), 256'(0));
        chk("t3_rdata",  rdata_flat, 256'(0));

        // 4: start re-pulsed mid-ISSUE is ignored
        fill(16'h0030, 16'hB000);
        launch(1'b1, 16'h00F0);
        observe(40, 2);
        chk("t4_en_n",   256'(en_n), 256'(4));
        chk("t4_done",   256'(done_cyc), 256'(5));
        chk("t4_done_n", 256'(done_n), 256'(1));
        for (int i = 0; i < seen.size(); i++)
            chk($sformatf("t4_order%0d", i), 256'(seen[i]), 256'(16'h34 + i));
        chk("t4_mem37", 256'(mem[8'h37]), 256'(16'hB007));

        // 5: two stores to one address, higher lane wins
        fill(16'h0040, 16'h0000);
        addr_flat[16 +: 16]  = 16'h0020;
        addr_flat[32 +: 16]  = 16'h0020;
        wdata_flat[16 +: 16] = 16'h1111;
        wdata_flat[32 +: 16] = 16'h2222;
        launch(1'b1, 16'h0006);
        observe(20, 0);
        chk("t5_en_n",  256'(en_n), 256'(2));
        chk("t5_done",  256'(done_cyc), 256'(3));
        chk("t5_mem20", 256'(mem[8'h20]), 256'(16'h2222));

        // 6: reset during cycle 3 of a 16-lane load
        fill(16'h0010, 16'h0000);
        launch(1'b0, 16'hFFFF);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("t6_pre_en",    256'(mem_en), 256'(1));
        chk("t6_pre_lane0", 256'(rdata_flat[15:0]), 256'(16'hA000));
        reset = 1'b1;
        #1;
        chk("t6_en",    256'(mem_en), 256'(0));
        chk("t6_busy",  256'(busy), 256'(0));
        chk("t6_rdata", rdata_flat, 256'(0));
        @(posedge clk); #1;
        reset = 1'b0;
        observe(20, 0);
        chk("t6_no_done", 256'(done_n), 256'(0));
        chk("t6_no_en",   256'(en_n), 256'(0));

        launch(1'b0, 16'hFFFF);
        observe(40, 0);
        chk("t6b_en_n", 256'(en_n), 256'(16));
        chk("t6b_done", 256'(done_cyc), 256'(18));
        for (int i = 0; i < 16; i++) exp_v[i*16 +: 16] = 16'hA000 + 16'(i);
        chk("t6b_rdata", rdata_flat, exp_v);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
